regread_forward: RTL and testbench
==================================

# regread_forward

Register-read/operand-bypass stage sitting between decode (ID) and execute (EXE). It is the consumer end of the per-stage forwarding interface (`forwardMode`/`writeNum`/data) driven by the EXE, REEXE and MEM stages. It holds one instruction, resolves both source operands from the youngest matching producer or the GPR file, and tracks in-flight writers in a per-GPR scoreboard. It stalls issue while any operand is unavailable.

## Interface
Parameters: none. GPR number width 5, data width 32.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ID_valid_w_i  in  1  ID holds an instruction for this stage
- EXE_allowin_w_i  in  1  EXE accepts an instruction this cycle
- flush_w_i  in  1  pipeline flush (exception/redirect)
- ID_rs_i, ID_rt_i  in  5  source GPR numbers; 0 means unused
- ID_writeNum_i  in  5  destination GPR; 0 means no writeback
- ID_VAddr_i  in  32  instruction PC
- RR_rsNum_o, RR_rtNum_o  out  5  GPR file read addresses, taken from the stage register
- GPR_rsData_i, GPR_rtData_i  in  32  GPR file read data, combinational
- EXE_/REEXE_/MEM_writeNum_w_i  in  5  producer destination; 0 means stage empty
- EXE_/REEXE_/MEM_forwardMode_w_i  in  1  producer data valid this cycle
- EXE_/REEXE_/MEM_data_w_i  in  32  producer result
- WB_writeEn_w_i  in  1  GPR write this cycle
- WB_writeNum_w_i  in  5  GPR written
- WB_data_w_i  in  32  GPR write data
- RR_okToChange_w_o  out  1  allowin to ID
- RR_valid_w_o  out  1  instruction issues to EXE this cycle
- RR_rsData_o, RR_rtData_o  out  32  resolved operands
- RR_writeNum_o  out  5  registered destination
- RR_VAddr_o  out  32  registered PC

## Operation
- Stage register holds rs, rt, writeNum, VAddr, plus hasData.
- Operand resolution, applied independently to rs and rt (src):
  - If src == 0, the value is 0 and there is no stall.
  - Otherwise the first match in priority order EXE > REEXE > MEM > WB supplies the value.
  - EXE/REEXE/MEM match when the stage's writeNum == src. If that stage's forwardMode=1, use its data. If forwardMode=0, stall; a lower-priority match is never used.
  - WB matches when WB_writeEn && WB_writeNum == src; use WB_data.
  - With no match: if scoreboard[src] != 0, stall. Otherwise use the GPR data.
- Scoreboard: 32 entries, 2-bit counters; entry 0 is always 0.
  - Increment [RR_writeNum_o] when RR_valid_w_o && RR_writeNum_o != 0.
  - Decrement [WB_writeNum] when WB_writeEn && WB_writeNum != 0.
  - Increment and decrement of the same entry in the same cycle leave it unchanged.
  - Issue is blocked while scoreboard[RR_writeNum_o] == 3 (sbFull), so counters never overflow.
  - Decrement of a 0 entry is illegal and is an assertion failure in the bench.
- ready = !(rsStall || rtStall || sbFull).
- RR_valid_w_o = hasData && ready && EXE_allowin_w_i.
- RR_okToChange_w_o = !hasData || (ready && EXE_allowin_w_i).
- Update rules, in priority order:
  - !rst or flush_w_i: clear the stage register, hasData and the whole scoreboard.
  - Else if okToChange && ID_valid: load the stage register and set hasData=1.
  - Else if okToChange && !ID_valid: clear the stage register and hasData.
  - Else hold.

## Timing
- Reset values: RR_valid_w_o=0, RR_okToChange_w_o=1, RR_writeNum_o=0, RR_VAddr_o=0, RR_rsNum_o=RR_rtNum_o=0, all scoreboard counters 0.
- With no stalls, a cycle-N acceptance appears at the outputs in cycle N+1.
- Forwarding mux, stall detection and RR_valid_w_o are combinational in the current cycle. No operand data is registered.
- Scoreboard increment is visible the cycle after issue. Back-to-back dependent instructions are covered in that cycle by the EXE writeNum match.
- WB bypass ensures no extra bubble when the GPR file write lands at the same edge.
- Flush in the same cycle as a load or issue: the flush wins, and no scoreboard increment occurs.
- The stage holds while EXE_allowin_w_i=0 even when ready=1.

## Test plan
- Reset with rst=0 for 2 cycles -> RR_valid_w_o=0, RR_okToChange_w_o=1, all outputs 0, every scoreboard entry 0.
- Independent stream `add r3,r1,r2` (GPR r1=5, r2=7) -> issues 1 cycle after ID, RR_rsData_o=5, RR_rtData_o=7, one issue per cycle.
- EXE writeNum=3 with forwardMode=0 and REEXE writeNum=3, data 0x11, forwardMode=1; instruction reads r3 -> stalls, RR_okToChange_w_o=0. Next cycle EXE forwardMode=1, data 0x22 -> issues with RR_rsData_o=0x22, not 0x11.
- Three issues writing r4 with no WB -> scoreboard[r4]=3 and the fourth writer to r4 is held. WB writes r4 -> the fourth issues next cycle and the entry returns to 3. A reader of r4 with no forwarding match stalls until the entry reaches 0.
- Same-cycle issue writing r6 and WB write of r6 with scoreboard[r6]=1 -> scoreboard[r6] stays at 1.
- flush_w_i asserted during a stall with scoreboard entries nonzero -> next cycle hasData=0, RR_valid_w_o=0, all entries 0, RR_okToChange_w_o=1.

Source files
------------

// File: rtl/regread_forward.sv
// Register-read / operand-bypass stage between ID and EXE. Resolves rs/rt from
// EXE > REEXE > MEM > WB forwarding or the GPR file, and tracks in-flight writers.
module regread_forward (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_valid_w_i,
    input  logic        EXE_allowin_w_i,
    input  logic        flush_w_i,
    input  logic [4:0]  ID_rs_i,
    input  logic [4:0]  ID_rt_i,
    input  logic [4:0]  ID_writeNum_i,
    input  logic [31:0] ID_VAddr_i,
    output logic [4:0]  RR_rsNum_o,
    output logic [4:0]  RR_rtNum_o,
    input  logic [31:0] GPR_rsData_i,
    input  logic [31:0] GPR_rtData_i,
    input  logic [4:0]  EXE_writeNum_w_i,
    input  logic        EXE_forwardMode_w_i,
    input  logic [31:0] EXE_data_w_i,
    input  logic [4:0]  REEXE_writeNum_w_i,
    input  logic        REEXE_forwardMode_w_i,
    input  logic [31:0] REEXE_data_w_i,
    input  logic [4:0]  MEM_writeNum_w_i,
    input  logic        MEM_forwardMode_w_i,
    input  logic [31:0] MEM_data_w_i,
    input  logic        WB_writeEn_w_i,
    input  logic [4:0]  WB_writeNum_w_i,
    input  logic [31:0] WB_data_w_i,
    output logic        RR_okToChange_w_o,
    output logic        RR_valid_w_o,
    output logic [31:0] RR_rsData_o,
    output logic [31:0] RR_rtData_o,
    output logic [4:0]  RR_writeNum_o,
    output logic [31:0] RR_VAddr_o
);

    logic [4:0]  rs_q, rt_q, wn_q;
    logic [31:0] vaddr_q;
    logic        has_data;
    logic [1:0]  sb [32];

    logic [32:0] rs_res, rt_res;
    logic        rs_stall, rt_stall, sb_full, ready;

    // Returns {stall, data}. A busy producer (forwardMode=0) blocks lower-priority matches.
    function automatic logic [32:0] resolve(input logic [4:0] src, input logic [31:0] gpr_data);
        logic [32:0] r;
        r = {1'b0, gpr_data};
        if (src == 5'd0)
            r = 33'd0;
        else if (EXE_writeNum_w_i == src)
            r = EXE_forwardMode_w_i ? {1'b0, EXE_data_w_i} : {1'b1, 32'd0};
        else if (REEXE_writeNum_w_i == src)
            r = REEXE_forwardMode_w_i ? {1'b0, REEXE_data_w_i} : {1'b1, 32'd0};
        else if (MEM_writeNum_w_i == src)
            r = MEM_forwardMode_w_i ? {1'b0, MEM_data_w_i} : {1'b1, 32'd0};
        else if (WB_writeEn_w_i && WB_writeNum_w_i == src)
            r = {1'b0, WB_data_w_i};
        else if (sb[src] != 2'd0)
            r = {1'b1, 32'd0};
        return r;
    endfunction

    always_comb begin
        rs_res   = resolve(rs_q, GPR_rsData_i);
        rt_res   = resolve(rt_q, GPR_rtData_i);
        rs_stall = rs_res[32];
        rt_stall = rt_res[32];
        sb_full  = (sb[wn_q] == 2'd3);
        ready    = !(rs_stall || rt_stall || sb_full);
    end

    assign RR_valid_w_o      = has_data && ready && EXE_allowin_w_i;
    assign RR_okToChange_w_o = !has_data || (ready && EXE_allowin_w_i);
    assign RR_rsData_o       = rs_res[31:0];
    assign RR_rtData_o       = rt_res[31:0];
    assign RR_rsNum_o        = rs_q;
    assign RR_rtNum_o        = rt_q;
    assign RR_writeNum_o     = wn_q;
    assign RR_VAddr_o        = vaddr_q;

    always_ff @(posedge clk) begin
        if (!rst || flush_w_i) begin
            rs_q     <= '0;
            rt_q     <= '0;
            wn_q     <= '0;
            vaddr_q  <= '0;
            has_data <= 1'b0;
        end else if (RR_okToChange_w_o && ID_valid_w_i) begin
            rs_q     <= ID_rs_i;
            rt_q     <= ID_rt_i;
            wn_q     <= ID_writeNum_i;
            vaddr_q  <= ID_VAddr_i;
            has_data <= 1'b1;
        end else if (RR_okToChange_w_o) begin
            rs_q     <= '0;
            rt_q     <= '0;
            wn_q     <= '0;
            vaddr_q  <= '0;
            has_data <= 1'b0;
        end
    end

    // Counter per GPR of issued-but-not-written-back producers; entry 0 stays 0.
    always_ff @(posedge clk) begin
        if (!rst || flush_w_i) begin
            for (int i = 0; i < 32; i++) sb[i] <= 2'd0;
        end else begin
            sb[0] <= 2'd0;
            for (int i = 1; i < 32; i++) begin
                if ((RR_valid_w_o && wn_q == 5'(i)) && !(WB_writeEn_w_i && WB_writeNum_w_i == 5'(i)))
                    sb[i] <= sb[i] + 2'd1;
                else if (!(RR_valid_w_o && wn_q == 5'(i)) && (WB_writeEn_w_i && WB_writeNum_w_i == 5'(i)))
                    sb[i] <= sb[i] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_regread_forward.sv
// Directed bench for regread_forward: forwarding priority, scoreboard limits,
// WB bypass, allowin hold and flush.
module tb_regread_forward;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_valid_w_i, EXE_allowin_w_i, flush_w_i;
    logic [4:0]  ID_rs_i, ID_rt_i, ID_writeNum_i;
    logic [31:0] ID_VAddr_i;
    logic [4:0]  RR_rsNum_o, RR_rtNum_o;
    logic [31:0] GPR_rsData_i, GPR_rtData_i;
    logic [4:0]  EXE_writeNum_w_i, REEXE_writeNum_w_i, MEM_writeNum_w_i;
    logic        EXE_forwardMode_w_i, REEXE_forwardMode_w_i, MEM_forwardMode_w_i;
    logic [31:0] EXE_data_w_i, REEXE_data_w_i, MEM_data_w_i;
    logic        WB_writeEn_w_i;
    logic [4:0]  WB_writeNum_w_i;
    logic [31:0] WB_data_w_i;
    logic        RR_okToChange_w_o, RR_valid_w_o;
    logic [31:0] RR_rsData_o, RR_rtData_o;
    logic [4:0]  RR_writeNum_o;
    logic [31:0] RR_VAddr_o;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] gpr_mem [32];

    always #5 clk = ~clk;

    assign GPR_rsData_i = gpr_mem[RR_rsNum_o];
    assign GPR_rtData_i = gpr_mem[RR_rtNum_o];

    regread_forward dut (
        .clk(clk), .rst(rst),
        .ID_valid_w_i(ID_valid_w_i), .EXE_allowin_w_i(EXE_allowin_w_i), .flush_w_i(flush_w_i),
        .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i), .ID_writeNum_i(ID_writeNum_i), .ID_VAddr_i(ID_VAddr_i),
        .RR_rsNum_o(RR_rsNum_o), .RR_rtNum_o(RR_rtNum_o),
        .GPR_rsData_i(GPR_rsData_i), .GPR_rtData_i(GPR_rtData_i),
        .EXE_writeNum_w_i(EXE_writeNum_w_i), .EXE_forwardMode_w_i(EXE_forwardMode_w_i), .EXE_data_w_i(EXE_data_w_i),
        .REEXE_writeNum_w_i(REEXE_writeNum_w_i), .REEXE_forwardMode_w_i(REEXE_forwardMode_w_i), .REEXE_data_w_i(REEXE_data_w_i),
        .MEM_writeNum_w_i(MEM_writeNum_w_i), .MEM_forwardMode_w_i(MEM_forwardMode_w_i), .MEM_data_w_i(MEM_data_w_i),
        .WB_writeEn_w_i(WB_writeEn_w_i), .WB_writeNum_w_i(WB_writeNum_w_i), .WB_data_w_i(WB_data_w_i),
        .RR_okToChange_w_o(RR_okToChange_w_o), .RR_valid_w_o(RR_valid_w_o),
        .RR_rsData_o(RR_rsData_o), .RR_rtData_o(RR_rtData_o),
        .RR_writeNum_o(RR_writeNum_o), .RR_VAddr_o(RR_VAddr_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] wn, input logic [31:0] pc);
        ID_valid_w_i  = v;
        ID_rs_i       = rs;
        ID_rt_i       = rt;
        ID_writeNum_i = wn;
        ID_VAddr_i    = pc;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] wn, input logic [31:0] d);
        WB_writeEn_w_i  = en;
        WB_writeNum_w_i = wn;
        WB_data_w_i     = d;
    endtask

    function automatic logic [31:0] sb_nonzero();
        logic [31:0] n;
        n = 0;
        for (int i = 0; i < 32; i++) if (dut.sb[i] != 2'd0) n = n + 1;
        return n;
    endfunction

    // Retiring a writer that was never counted is illegal.
    always @(posedge clk) begin
        if (rst === 1'b1 && flush_w_i === 1'b0 && WB_writeEn_w_i === 1'b1 && WB_writeNum_w_i != 5'd0) begin
            n_total = n_total + 1;
            assert (dut.sb[WB_writeNum_w_i] != 2'd0) n_pass = n_pass + 1;
            else $error("FAIL sb_underflow: entry %0d observed %0d expected nonzero",
                        WB_writeNum_w_i, dut.sb[WB_writeNum_w_i]);
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) gpr_mem[i] = 32'h1000 + i;
        gpr_mem[1] = 32'd5;
        gpr_mem[2] = 32'd7;

        rst = 1'b0;
        EXE_allowin_w_i = 1'b1;
        flush_w_i = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        EXE_writeNum_w_i = 0;   EXE_forwardMode_w_i = 0;   EXE_data_w_i = 0;
        REEXE_writeNum_w_i = 0; REEXE_forwardMode_w_i = 0; REEXE_data_w_i = 0;
        MEM_writeNum_w_i = 0;   MEM_forwardMode_w_i = 0;   MEM_data_w_i = 0;

        // Reset
        tick(); tick();
        check("rst_valid", {31'd0, RR_valid_w_o}, 32'd0);
        check("rst_ok", {31'd0, RR_okToChange_w_o}, 32'd1);
        check("rst_wn", {27'd0, RR_writeNum_o}, 32'd0);
        check("rst_vaddr", RR_VAddr_o, 32'd0);
        check("rst_rsnum", {27'd0, RR_rsNum_o}, 32'd0);
        check("rst_rtnum", {27'd0, RR_rtNum_o}, 32'd0);
        check("rst_sb", sb_nonzero(), 32'd0);
        rst = 1'b1;

        // Independent stream: add r3,r1,r2 then add r8,r1,r2
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h100);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h104);
        #1;
        check("s1_valid", {31'd0, RR_valid_w_o}, 32'd1);
        check("s1_rs", RR_rsData_o, 32'd5);
        check("s1_rt", RR_rtData_o, 32'd7);
        check("s1_wn", {27'd0, RR_writeNum_o}, 32'd3);
        check("s1_vaddr", RR_VAddr_o, 32'h100);
        check("s1_ok", {31'd0, RR_okToChange_w_o}, 32'd1);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        check("s2_valid", {31'd0, RR_valid_w_o}, 32'd1);
        check("s2_vaddr", RR_VAddr_o, 32'h104);
        check("s2_wn", {27'd0, RR_writeNum_o}, 32'd8);
        check("s2_sb3", {30'd0, dut.sb[3]}, 32'd1);
        tick();
        check("s3_empty_valid", {31'd0, RR_valid_w_o}, 32'd0);
        check("s3_empty_ok", {31'd0, RR_okToChange_w_o}, 32'd1);
        check("s3_sb8", {30'd0, dut.sb[8]}, 32'd1);
        flush_w_i = 1'b1;
        tick();
        flush_w_i = 1'b0;
        #1;
        check("s3_flush_sb", sb_nonzero(), 32'd0);

        // EXE busy on r3 blocks the ready REEXE copy
        EXE_writeNum_w_i = 5'd3;   EXE_forwardMode_w_i = 1'b0;   EXE_data_w_i = 32'hdead;
        REEXE_writeNum_w_i = 5'd3; REEXE_forwardMode_w_i = 1'b1; REEXE_data_w_i = 32'h11;
        set_id(1'b1, 5'd3, 5'd0, 5'd9, 32'h200);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        check("fw_stall_valid", {31'd0, RR_valid_w_o}, 32'd0);
        check("fw_stall_ok", {31'd0, RR_okToChange_w_o}, 32'd0);
        check("fw_rt_zero", RR_rtData_o, 32'd0);
        tick();
        EXE_forwardMode_w_i = 1'b1; EXE_data_w_i = 32'h22;
        #1;
        check("fw_issue_valid", {31'd0, RR_valid_w_o}, 32'd1);
        check("fw_issue_rs", RR_rsData_o, 32'h22);
        check("fw_issue_vaddr", RR_VAddr_o, 32'h200);
        tick();
        EXE_writeNum_w_i = 0; EXE_forwardMode_w_i = 0; EXE_data_w_i = 0;
        REEXE_writeNum_w_i = 0; REEXE_forwardMode_w_i = 0; REEXE_data_w_i = 0;
        #1;
        check("fw_after_valid", {31'd0, RR_valid_w_o}, 32'd0);

        // EXE not accepting holds a ready instruction; MEM forwards rt
        MEM_writeNum_w_i = 5'd2; MEM_forwardMode_w_i = 1'b1; MEM_data_w_i = 32'h55;
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'h300);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        EXE_allowin_w_i = 1'b0;
        #1;
        check("hold_valid", {31'd0, RR_valid_w_o}, 32'd0);
        check("hold_ok", {31'd0, RR_okToChange_w_o}, 32'd0);
        tick();
        EXE_allowin_w_i = 1'b1;
        #1;
        check("hold_issue_valid", {31'd0, RR_valid_w_o}, 32'd1);
        check("hold_issue_vaddr", RR_VAddr_o, 32'h300);
        check("mem_fw_rt", RR_rtData_o, 32'h55);
        check("mem_gpr_rs", RR_rsData_o, 32'd5);
        tick();
        MEM_writeNum_w_i = 0; MEM_forwardMode_w_i = 0; MEM_data_w_i = 0;
        flush_w_i = 1'b1;
        tick();
        flush_w_i = 1'b0;

        // Four writers of r4: the fourth waits for a writeback
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h400);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h404);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h408);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h40c);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        check("sbfull_cnt", {30'd0, dut.sb[4]}, 32'd3);
        check("sbfull_valid", {31'd0, RR_valid_w_o}, 32'd0);
        check("sbfull_ok", {31'd0, RR_okToChange_w_o}, 32'd0);
        check("sbfull_vaddr", RR_VAddr_o, 32'h40c);
        tick();
        check("sbfull_hold", {31'd0, RR_valid_w_o}, 32'd0);
        set_wb(1'b1, 5'd4, 32'h44);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        #1;
        check("sbfull_cnt2", {30'd0, dut.sb[4]}, 32'd2);
        check("sbfull_issue", {31'd0, RR_valid_w_o}, 32'd1);
        tick();
        check("sbfull_cnt3", {30'd0, dut.sb[4]}, 32'd3);

        // Reader of r4 waits for the last writeback, taking it via WB bypass
        set_wb(1'b1, 5'd4, 32'h41);
        tick();
        set_wb(1'b1, 5'd4, 32'h42);
        set_id(1'b1, 5'd4, 5'd0, 5'd0, 32'h500);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        check("rd4_cnt1", {30'd0, dut.sb[4]}, 32'd1);
        check("rd4_stall", {31'd0, RR_valid_w_o}, 32'd0);
        check("rd4_stall_ok", {31'd0, RR_okToChange_w_o}, 32'd0);
        tick();
        check("rd4_still", {31'd0, RR_valid_w_o}, 32'd0);
        set_wb(1'b1, 5'd4, 32'h4c);
        #1;
        check("rd4_wb_valid", {31'd0, RR_valid_w_o}, 32'd1);
        check("rd4_wb_rs", RR_rsData_o, 32'h4c);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        #1;
        check("rd4_cnt0", {30'd0, dut.sb[4]}, 32'd0);

        // Issue and writeback of r6 in the same cycle
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h600);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h604);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        set_wb(1'b1, 5'd6, 32'h66);
        #1;
        check("same_issue", {31'd0, RR_valid_w_o}, 32'd1);
        check("same_cnt_before", {30'd0, dut.sb[6]}, 32'd1);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        #1;
        check("same_cnt_after", {30'd0, dut.sb[6]}, 32'd1);

        // Flush while a reader of r6 stalls
        set_id(1'b1, 5'd6, 5'd0, 5'd7, 32'h700);
        tick();
        set_id(1'b1, 5'd1, 5'd1, 5'd9, 32'h704);
        #1;
        check("fl_stall", {31'd0, RR_valid_w_o}, 32'd0);
        flush_w_i = 1'b1;
        tick();
        flush_w_i = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        check("fl_valid", {31'd0, RR_valid_w_o}, 32'd0);
        check("fl_ok", {31'd0, RR_okToChange_w_o}, 32'd1);
        check("fl_vaddr", RR_VAddr_o, 32'd0);
        check("fl_wn", {27'd0, RR_writeNum_o}, 32'd0);
        check("fl_sb", sb_nonzero(), 32'd0);

        // Flush in the issue cycle suppresses the increment
        set_id(1'b1, 5'd0, 5'd0, 5'd10, 32'h800);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        flush_w_i = 1'b1;
        #1;
        check("fli_valid", {31'd0, RR_valid_w_o}, 32'd1);
        tick();
        flush_w_i = 1'b0;
        #1;
        check("fli_sb10", {30'd0, dut.sb[10]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
